// File: rtl/func_share_arbiter_if.sv
// Handshake bundle between the requesters and the shared function arbiter.
// The arbiter takes the slave view; the producers take the master view.
interface func_share_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 32,
   parameter int OUT_W = 4,
   parameter int IDW   = 2
);
   logic [NREQ-1:0]      req;
   logic [NREQ*IN_W-1:0] operand;
   logic [NREQ-1:0]      gnt;
   logic                 busy;
   logic                 res_valid;
   logic [OUT_W-1:0]     res_data;
   logic [IDW-1:0]       res_id;

   modport master (
      output req, operand,
      input  gnt, busy, res_valid, res_data, res_id
   );

   modport slave (
      input  req, operand,
      output gnt, busy, res_valid, res_data, res_id
   );
endinterface

// File: rtl/func_share_arbiter.sv
// Round-robin arbiter sharing one fixed-latency truncating evaluator among
// NREQ requesters; results come back tagged with the owning requester index.
module func_share_arbiter #(
   parameter int NREQ  = 4,
   parameter int IN_W  = 32,
   parameter int OUT_W = 4,
   parameter int LAT   = 2,
   parameter int IDW   = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   func_share_arbiter_if.slave   bus
);

   localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state;
   logic [IDW-1:0]   ptr;
   logic [CNT_W-1:0] cnt;
   logic [OUT_W-1:0] op_q;
   logic [IDW-1:0]   id_q;

   logic             any_req;
   logic [IDW-1:0]   win;
   logic [IDW-1:0]   ptr_next;
   logic [NREQ-1:0]  win_onehot;
   logic [OUT_W-1:0] win_op;

   // Scan from ptr upward with wrap; the first set request wins.
   // NOTE: every variable written here gets a default first, so no latch is inferred.
   always_comb begin
      int idx;
      any_req = 1'b0;
      win     = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         if (!any_req && bus.req[idx]) begin
            any_req = 1'b1;
            win     = IDW'(idx);
         end
      end
   end

   assign ptr_next   = (int'(win) == NREQ - 1) ? '0 : win + IDW'(1);
   assign win_onehot = {{(NREQ-1){1'b0}}, 1'b1} << win;

   // Only the bits that survive truncation are worth holding.
   assign win_op = bus.operand[int'(win)*IN_W +: OUT_W];

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         ptr           <= '0;
         cnt           <= '0;
         op_q          <= '0;
         id_q          <= '0;
         bus.gnt       <= '0;
         bus.busy      <= 1'b0;
         bus.res_valid <= 1'b0;
         bus.res_data  <= '0;
         bus.res_id    <= '0;
      end else begin
         bus.gnt       <= '0;
         bus.res_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (any_req) begin
                  bus.gnt  <= win_onehot;
                  bus.busy <= 1'b1;
                  op_q     <= win_op;
                  id_q     <= win;
                  ptr      <= ptr_next;
                  cnt      <= CNT_W'(LAT - 1);
                  state    <= EXEC;
               end
            end
            EXEC: begin
               if (cnt == '0) begin
                  bus.res_valid <= 1'b1;
                  bus.res_data  <= op_q;
                  bus.res_id    <= id_q;
                  state         <= RESP;
               end else begin
                  cnt <= cnt - CNT_W'(1);
               end
            end
            RESP: begin
               // Requests are ignored here; they are picked up next IDLE.
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
            default: begin
               bus.busy <= 1'b0;
               state    <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_func_share_arbiter.sv
// Directed bench for func_share_arbiter: reset, truncation, round-robin order,
// wrap/skip, late operand change, req drop and mid-transaction reset.
module tb_func_share_arbiter;

   localparam int NREQ  = 4;
   localparam int IN_W  = 32;
   localparam int OUT_W = 4;
   localparam int LAT   = 2;
   localparam int IDW   = 2;

   logic clk;
   logic rst_n;
   int   vectors     = 0;
   int   miscompares = 0;

   func_share_arbiter_if #(
      .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .IDW(IDW)
   ) bus ();

   func_share_arbiter #(
      .NREQ(NREQ), .IN_W(IN_W), .OUT_W(OUT_W), .LAT(LAT), .IDW(IDW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_op(input int i, input logic [IN_W-1:0] v);
      bus.operand[i*IN_W +: IN_W] = v;
   endtask

   logic [IN_W-1:0] ops [NREQ];
   logic [IN_W-1:0] opv;
   int              exp_id;
   bit              seen;
   int              waited;

   initial begin
      rst_n       = 1'b0;
      bus.req     = '0;
      bus.operand = '0;

      // Reset held for two cycles
      step();
      step();
      rst_n = 1'b1;
      step();
      check("rst_gnt",       32'(bus.gnt),       32'h0);
      check("rst_busy",      32'(bus.busy),      32'h0);
      check("rst_res_valid", 32'(bus.res_valid), 32'h0);
      check("rst_res_data",  32'(bus.res_data),  32'h0);
      check("rst_res_id",    32'(bus.res_id),    32'h0);

      // Single request from requester 0
      set_op(0, 32'h0000_0008);
      bus.req = 4'b0001;
      step();
      check("single_gnt",  32'(bus.gnt),  32'h1);
      check("single_busy", 32'(bus.busy), 32'h1);
      bus.req = 4'b0000;
      step();
      check("single_gnt_pulse", 32'(bus.gnt),       32'h0);
      check("single_early_val", 32'(bus.res_valid), 32'h0);
      step();
      check("single_val",  32'(bus.res_valid), 32'h1);
      check("single_data", 32'(bus.res_data),  32'h8);
      check("single_id",   32'(bus.res_id),    32'h0);
      step();
      check("single_val_fall", 32'(bus.res_valid), 32'h0);
      check("single_busy_low", 32'(bus.busy),      32'h0);
      check("single_data_hold", 32'(bus.res_data), 32'h8);

      // Truncation: ptr=1, requester 2 wins
      set_op(2, 32'hDEAD_BEE5);
      bus.req = 4'b0100;
      step();
      check("trunc_gnt", 32'(bus.gnt), 32'h4);
      bus.req = 4'b0000;
      step();
      step();
      check("trunc_val",  32'(bus.res_valid), 32'h1);
      check("trunc_data", 32'(bus.res_data),  32'h5);
      check("trunc_id",   32'(bus.res_id),    32'h2);
      step();

      // Zero operand on requester 3 (ptr=3); ptr then wraps to 0
      set_op(3, 32'h0000_0000);
      bus.req = 4'b1000;
      step();
      check("zero_gnt", 32'(bus.gnt), 32'h8);
      bus.req = 4'b0000;
      step();
      step();
      check("zero_val",  32'(bus.res_valid), 32'h1);
      check("zero_data", 32'(bus.res_data),  32'h0);
      check("zero_id",   32'(bus.res_id),    32'h3);
      step();

      // Round-robin under continuous request
      ops[0] = 32'h0000_00A1;
      ops[1] = 32'h1111_111C;
      ops[2] = 32'hCAFE_F00D;
      ops[3] = 32'h8000_0007;
      for (int i = 0; i < NREQ; i++) set_op(i, ops[i]);
      bus.req = 4'b1111;
      for (int t = 0; t < 8; t++) begin
         exp_id = t % NREQ;
         opv    = ops[exp_id];
         step();
         check($sformatf("rr%0d_gnt", t), 32'(bus.gnt), 32'(1) << exp_id);
         step();
         step();
         check($sformatf("rr%0d_val", t),  32'(bus.res_valid), 32'h1);
         check($sformatf("rr%0d_id", t),   32'(bus.res_id),    32'(exp_id));
         check($sformatf("rr%0d_data", t), 32'(bus.res_data),  32'(opv[3:0]));
         step();
         check($sformatf("rr%0d_idle", t), 32'(bus.busy), 32'h0);
      end
      bus.req = 4'b0000;

      // Move ptr to 3 with a grant to requester 2
      set_op(2, 32'h0000_0002);
      bus.req = 4'b0100;
      step();
      check("pre_wrap_gnt", 32'(bus.gnt), 32'h4);
      bus.req = 4'b0000;
      step();
      step();
      step();

      // Wrap and skip: req=0101 from ptr 3 gives 0 then 2
      set_op(0, 32'h0000_00B4);
      set_op(2, 32'h0000_0C09);
      bus.req = 4'b0101;
      step();
      check("wrap_gnt0", 32'(bus.gnt), 32'h1);
      bus.req = 4'b0100;
      step();
      step();
      check("wrap_id0",   32'(bus.res_id),   32'h0);
      check("wrap_data0", 32'(bus.res_data), 32'h4);
      step();
      step();
      check("wrap_gnt2", 32'(bus.gnt), 32'h4);
      bus.req = 4'b0000;
      step();
      step();
      check("wrap_id2",   32'(bus.res_id),   32'h2);
      check("wrap_data2", 32'(bus.res_data), 32'h9);
      step();

      // Late operand change and req drop during EXEC (ptr=3 -> requester 1)
      set_op(1, 32'h0000_0003);
      bus.req = 4'b0010;
      step();
      check("late_gnt", 32'(bus.gnt), 32'h2);
      set_op(1, 32'h0000_000F);
      bus.req = 4'b0000;
      step();
      step();
      check("late_val",  32'(bus.res_valid), 32'h1);
      check("late_data", 32'(bus.res_data),  32'h3);
      check("late_id",   32'(bus.res_id),    32'h1);
      step();

      // Reset during EXEC aborts the transaction (ptr=2 -> requester 2)
      set_op(2, 32'h0000_0009);
      bus.req = 4'b0100;
      step();
      check("abort_gnt", 32'(bus.gnt), 32'h4);
      bus.req = 4'b0000;
      step();
      rst_n = 1'b0;
      step();
      check("abort_val",  32'(bus.res_valid), 32'h0);
      check("abort_busy", 32'(bus.busy),      32'h0);
      check("abort_data", 32'(bus.res_data),  32'h0);
      rst_n = 1'b1;
      seen  = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.res_valid) seen = 1'b1;
      end
      check("abort_no_result", 32'(seen), 32'h0);

      // After reset ptr=0, so req=1010 grants requester 1
      set_op(1, 32'h1234_5676);
      set_op(3, 32'h0000_0001);
      bus.req = 4'b1010;
      step();
      check("post_rst_gnt", 32'(bus.gnt), 32'h2);
      bus.req = 4'b1000;
      waited = 0;
      while (!bus.res_valid && waited < 10) begin
         step();
         waited++;
      end
      check("post_rst_latency", 32'(waited), 32'(LAT));
      check("post_rst_id",      32'(bus.res_id),   32'h1);
      check("post_rst_data",    32'(bus.res_data), 32'h6);
      step();
      step();
      check("held_off_gnt", 32'(bus.gnt), 32'h8);
      bus.req = 4'b0000;
      step();
      step();
      check("held_off_id",   32'(bus.res_id),   32'h3);
      check("held_off_data", 32'(bus.res_data), 32'h1);
      step();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
